output_display_driver: RTL

- Sits directly downstream of the output register: takes its 8-bit result value and shows it in decimal on a 3-digit multiplexed seven-segment display.
- Converts binary to BCD with a sequential shift-add-3 (double-dabble) FSM, then latches the three digits.
- A free-running refresh counter scans the digits onto shared segment lines.

---
 rtl/output_display_driver.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/output_display_driver.sv
// output_display_driver
//   Shows an 8-bit result in decimal on a 3-digit multiplexed seven-segment
//   display. A double-dabble FSM converts one bit per cycle into BCD. The
//   resulting digits are latched into display registers. A free-running
//   scanner drives the digits onto the shared segment lines.
// Ports:
//   clkin  - clock, rising edge
//   clr    - asynchronous active-low reset
//   val    - binary value to display, sampled when load=1
//   load   - single-cycle strobe for val
//   seg    - segments {g,f,e,d,c,b,a}, registered
//   an     - digit enables, bit0 units .. bit2 hundreds, one-hot, registered
//   busy   - conversion in progress
module output_display_driver #(
  parameter int REFRESH_DIV    = 1000,
  parameter bit BLANK_LZ       = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clkin,
  input  logic       clr,
  input  logic [7:0] val,
  input  logic       load,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

  localparam logic [15:0] DIV_M1 = 16'(REFRESH_DIV - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_shift, r_pend_val;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_pend;
  logic [3:0]  r_hun, r_ten, r_uni;
  logic [15:0] r_rcnt;
  logic [1:0]  r_idx;

  logic        w_start, w_from_pend;
  logic [7:0]  w_src;
  logic [11:0] w_adj;
  logic [3:0]  w_dig;
  logic        w_blank;
  logic [6:0]  w_seg_hi;
  logic [2:0]  w_an_hi;

  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    for (int i = 0; i < 3; i++)
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    return r;
  endfunction

  // Active-high patterns; anything outside 0..9 is blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;  4'd3: p = 7'h4F;
      4'd4: p = 7'h66;  4'd5: p = 7'h6D;  4'd6: p = 7'h7D;  4'd7: p = 7'h07;
      4'd8: p = 7'h7F;  4'd9: p = 7'h6F;  default: p = 7'h00;
    endcase
    return p;
  endfunction

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clkin or negedge clr) begin
    if (!clr) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // A load seen in LATCH parks in the pending register; IDLE then picks it
  // up on the following cycle, so it is never lost.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_from_pend = 1'b0;
    case (r_state)
      IDLE: begin
        if (load)        w_start = 1'b1;
        else if (r_pend) begin w_start = 1'b1; w_from_pend = 1'b1; end
      end
      CONV:  if (r_cnt == 3'd7) w_next = LATCH;
      LATCH: begin
        if (r_pend) begin w_start = 1'b1; w_from_pend = 1'b1; end
        else        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (w_start) w_next = CONV;
  end

  assign w_src = w_from_pend ? r_pend_val : val;
  assign w_adj = add3(r_bcd);
  assign busy  = (r_state != IDLE);

  always_ff @(posedge clkin or negedge clr) begin
    if (!clr) begin
      r_shift    <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_hun      <= '0;
      r_ten      <= '0;
      r_uni      <= '0;
    end else begin
      if (w_start) begin
        r_shift <= w_src;
        r_bcd   <= '0;
        r_cnt   <= '0;
      end else if (r_state == CONV) begin
        {r_bcd, r_shift} <= {w_adj, r_shift} << 1;
        r_cnt            <= r_cnt + 3'd1;
      end
      // Display registers only ever see complete results.
      if (r_state == LATCH) begin
        r_hun <= r_bcd[11:8];
        r_ten <= r_bcd[7:4];
        r_uni <= r_bcd[3:0];
      end
      // A new load while busy wins over clearing the flag on restart.
      if (load && r_state != IDLE) begin
        r_pend     <= 1'b1;
        r_pend_val <= val;
      end else if (w_start) begin
        r_pend <= 1'b0;
      end
    end
  end

  // ---------------- scanner ----------------
  always_ff @(posedge clkin or negedge clr) begin
    if (!clr) begin
      r_rcnt <= '0;
      r_idx  <= '0;
    end else if (r_rcnt == DIV_M1) begin
      r_rcnt <= '0;
      r_idx  <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
    end else begin
      r_rcnt <= r_rcnt + 16'd1;
    end
  end

  always_comb begin
    w_dig   = r_uni;
    w_blank = 1'b0;
    case (r_idx)
      2'd1: begin w_dig = r_ten; w_blank = BLANK_LZ && r_hun == 4'd0 && r_ten == 4'd0; end
      2'd2: begin w_dig = r_hun; w_blank = BLANK_LZ && r_hun == 4'd0; end
      default: ;
    endcase
  end

  // A blanked digit still gets its enable so every digit has equal on-time.
  assign w_seg_hi = w_blank ? 7'h00 : seg7(w_dig);
  assign w_an_hi  = 3'b001 << r_idx;

  always_ff @(posedge clkin or negedge clr) begin
    if (!clr) begin
      seg <= {7{SEG_ACTIVE_LOW}};
      an  <= {3{SEG_ACTIVE_LOW}};
    end else begin
      seg <= w_seg_hi ^ {7{SEG_ACTIVE_LOW}};
      an  <= w_an_hi ^ {3{SEG_ACTIVE_LOW}};
    end
  end

endmodule
